// File: rtl/rcc_rtc_div_ratio_ctrl_pkg.sv
// Shared RCC constants for the RTC divider ratio path.
package rcc_rtc_div_ratio_ctrl_pkg;

  localparam int RCC_RATIO_WID   = 6;
  localparam int RCC_SYNC_STAGES = 2;

  // Hold time covers the divider's synchronizer plus margin for capture.
  localparam int RCC_SETTLE_CYC  = RCC_SYNC_STAGES + 2;

endpackage

// File: rtl/rcc_rtc_div_ratio_ctrl.sv
// Accepts prescaler-ratio writes and holds each applied ratio stable for a
// settle window, queuing at most one write that arrives mid-window.
module rcc_rtc_div_ratio_ctrl
  import rcc_rtc_div_ratio_ctrl_pkg::*;
#(
  parameter int RATIO_WID  = RCC_RATIO_WID,
  parameter int SETTLE_CYC = RCC_SETTLE_CYC,
  parameter logic [RATIO_WID-1:0] RST_RATIO = '0
) (
  input  logic                 i_clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic [RATIO_WID-1:0] wr_ratio,
  output logic [RATIO_WID-1:0] ratio,
  output logic                 busy,
  output logic                 upd_done,
  output logic                 overrun
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_SETTLE = 1'b1;

  localparam logic [7:0] CNT_LOAD = 8'(SETTLE_CYC - 1);

  if (SETTLE_CYC < 3 || SETTLE_CYC > 255) begin : g_bad_settle
    $error("rcc_rtc_div_ratio_ctrl: SETTLE_CYC must be in 3..255");
  end

  logic [0:0]           state;
  logic [7:0]           cnt;
  logic [RATIO_WID-1:0] pend;
  logic                 pend_v;

  assign busy = (state == ST_SETTLE);

  always_ff @(posedge i_clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      ratio    <= RST_RATIO;
      pend     <= '0;
      pend_v   <= 1'b0;
      upd_done <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      upd_done <= 1'b0;
      overrun  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (wr_en && (wr_ratio != ratio)) begin
            ratio <= wr_ratio;
            cnt   <= CNT_LOAD;
            state <= ST_SETTLE;
          end
        end
        default: begin
          if (cnt != '0) begin
            cnt <= cnt - 8'd1;
            if (wr_en) begin
              pend    <= wr_ratio;
              pend_v  <= 1'b1;
              overrun <= pend_v;
            end
          end else begin
            // Terminal cycle: close the window, chaining straight into the next one if work is queued.
            upd_done <= 1'b1;
            if (pend_v) begin
              ratio  <= pend;
              cnt    <= CNT_LOAD;
              pend_v <= wr_en;
              if (wr_en) begin
                pend <= wr_ratio;
              end
            end else if (wr_en) begin
              ratio <= wr_ratio;
              cnt   <= CNT_LOAD;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rcc_rtc_div_ratio_ctrl.sv
// Directed bench for rcc_rtc_div_ratio_ctrl at SETTLE_CYC=4, RST_RATIO=0.
module tb_rcc_rtc_div_ratio_ctrl;

  logic       i_clk;
  logic       rst_n;
  logic       wr_en;
  logic [5:0] wr_ratio;
  logic [5:0] ratio;
  logic       busy;
  logic       upd_done;
  logic       overrun;

  int errors = 0;
  int checks = 0;

  rcc_rtc_div_ratio_ctrl #(
    .RATIO_WID (6),
    .SETTLE_CYC(4),
    .RST_RATIO (6'd0)
  ) dut (
    .i_clk   (i_clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_ratio(wr_ratio),
    .ratio   (ratio),
    .busy    (busy),
    .upd_done(upd_done),
    .overrun (overrun)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Advance to 1 time unit past the next rising edge: the start of the next cycle.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic applyStimulus(input logic en, input logic [5:0] val, input logic rn);
    wr_en    = en;
    wr_ratio = val;
    rst_n    = rn;
  endtask

  task automatic checkOutput(input string tag, input logic [5:0] er, input logic eb,
                             input logic ed, input logic eo);
    logic [8:0] obs;
    logic [8:0] exp;
    obs = {ratio, busy, upd_done, overrun};
    exp = {er, eb, ed, eo};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: ratio/busy/done/ovr observed=%0d/%b/%b/%b expected=%0d/%b/%b/%b",
             tag, ratio, busy, upd_done, overrun, er, eb, ed, eo);
    end
  endtask

  // One cycle: drive this cycle's inputs, check this cycle's outputs, move on.
  task automatic step(input string tag, input logic en, input logic [5:0] val,
                      input logic [5:0] er, input logic eb, input logic ed, input logic eo);
    applyStimulus(en, val, 1'b1);
    checkOutput(tag, er, eb, ed, eo);
    tick();
  endtask

  task automatic do_reset();
    applyStimulus(1'b0, 6'd0, 1'b0);
    tick();
    tick();
    applyStimulus(1'b0, 6'd0, 1'b1);
  endtask

  initial begin
    applyStimulus(1'b0, 6'd0, 1'b0);
    tick();
    do_reset();
    checkOutput("reset", 6'd0, 1'b0, 1'b0, 1'b0);

    // Single write, full window
    step("A.c0", 1, 6'd5, 6'd0, 0, 0, 0);
    step("A.c1", 0, 6'd0, 6'd5, 1, 0, 0);
    step("A.c2", 0, 6'd0, 6'd5, 1, 0, 0);
    step("A.c3", 0, 6'd0, 6'd5, 1, 0, 0);
    step("A.c4", 0, 6'd0, 6'd5, 1, 0, 0);
    step("A.c5", 0, 6'd0, 6'd5, 0, 1, 0);
    step("A.c6", 0, 6'd0, 6'd5, 0, 0, 0);

    // Equal-value write in idle is ignored
    step("B.c0", 1, 6'd5, 6'd5, 0, 0, 0);
    step("B.c1", 0, 6'd0, 6'd5, 0, 0, 0);
    step("B.c2", 0, 6'd0, 6'd5, 0, 0, 0);

    // Pending write chained into a second window
    do_reset();
    step("C.c0", 1, 6'd5, 6'd0, 0, 0, 0);
    step("C.c1", 0, 6'd0, 6'd5, 1, 0, 0);
    step("C.c2", 1, 6'd7, 6'd5, 1, 0, 0);
    step("C.c3", 0, 6'd0, 6'd5, 1, 0, 0);
    step("C.c4", 0, 6'd0, 6'd5, 1, 0, 0);
    step("C.c5", 0, 6'd0, 6'd7, 1, 1, 0);
    step("C.c6", 0, 6'd0, 6'd7, 1, 0, 0);
    step("C.c7", 0, 6'd0, 6'd7, 1, 0, 0);
    step("C.c8", 0, 6'd0, 6'd7, 1, 0, 0);
    step("C.c9", 0, 6'd0, 6'd7, 0, 1, 0);
    step("C.c10", 0, 6'd0, 6'd7, 0, 0, 0);

    // Pending overwrite raises overrun; 7 never reaches ratio
    do_reset();
    step("D.c0", 1, 6'd5, 6'd0, 0, 0, 0);
    step("D.c1", 0, 6'd0, 6'd5, 1, 0, 0);
    step("D.c2", 1, 6'd7, 6'd5, 1, 0, 0);
    step("D.c3", 1, 6'd9, 6'd5, 1, 0, 0);
    step("D.c4", 0, 6'd0, 6'd5, 1, 0, 1);
    step("D.c5", 0, 6'd0, 6'd9, 1, 1, 0);
    step("D.c6", 0, 6'd0, 6'd9, 1, 0, 0);
    step("D.c7", 0, 6'd0, 6'd9, 1, 0, 0);
    step("D.c8", 0, 6'd0, 6'd9, 1, 0, 0);
    step("D.c9", 0, 6'd0, 6'd9, 0, 1, 0);
    step("D.c10", 0, 6'd0, 6'd9, 0, 0, 0);

    // Write on terminal cycle with nothing pending applies directly
    do_reset();
    step("E.c0", 1, 6'd5, 6'd0, 0, 0, 0);
    step("E.c1", 0, 6'd0, 6'd5, 1, 0, 0);
    step("E.c2", 0, 6'd0, 6'd5, 1, 0, 0);
    step("E.c3", 0, 6'd0, 6'd5, 1, 0, 0);
    step("E.c4", 1, 6'd6, 6'd5, 1, 0, 0);
    step("E.c5", 0, 6'd0, 6'd6, 1, 1, 0);
    step("E.c6", 0, 6'd0, 6'd6, 1, 0, 0);
    step("E.c7", 0, 6'd0, 6'd6, 1, 0, 0);
    step("E.c8", 0, 6'd0, 6'd6, 1, 0, 0);
    step("E.c9", 0, 6'd0, 6'd6, 0, 1, 0);

    // Terminal cycle with pending and a new write: write becomes next pending
    do_reset();
    step("G.c0", 1, 6'd5, 6'd0, 0, 0, 0);
    step("G.c1", 0, 6'd0, 6'd5, 1, 0, 0);
    step("G.c2", 1, 6'd7, 6'd5, 1, 0, 0);
    step("G.c3", 0, 6'd0, 6'd5, 1, 0, 0);
    step("G.c4", 1, 6'd9, 6'd5, 1, 0, 0);
    step("G.c5", 0, 6'd0, 6'd7, 1, 1, 0);
    step("G.c6", 0, 6'd0, 6'd7, 1, 0, 0);
    step("G.c7", 0, 6'd0, 6'd7, 1, 0, 0);
    step("G.c8", 0, 6'd0, 6'd7, 1, 0, 0);
    step("G.c9", 0, 6'd0, 6'd9, 1, 1, 0);
    step("G.c10", 0, 6'd0, 6'd9, 1, 0, 0);
    step("G.c11", 0, 6'd0, 6'd9, 1, 0, 0);
    step("G.c12", 0, 6'd0, 6'd9, 1, 0, 0);
    step("G.c13", 0, 6'd0, 6'd9, 0, 1, 0);

    // Reset mid-window drops the window, the pending write and a same-cycle write
    do_reset();
    step("F.c0", 1, 6'd5, 6'd0, 0, 0, 0);
    step("F.c1", 1, 6'd7, 6'd5, 1, 0, 0);
    applyStimulus(1'b1, 6'd4, 1'b0);
    checkOutput("F.c2", 6'd5, 1, 0, 0);
    tick();
    step("F.c3", 0, 6'd0, 6'd0, 0, 0, 0);
    step("F.c4", 0, 6'd0, 6'd0, 0, 0, 0);
    step("F.c5", 1, 6'd3, 6'd0, 0, 0, 0);
    step("F.c6", 0, 6'd0, 6'd3, 1, 0, 0);
    step("F.c7", 0, 6'd0, 6'd3, 1, 0, 0);
    step("F.c8", 0, 6'd0, 6'd3, 1, 0, 0);
    step("F.c9", 0, 6'd0, 6'd3, 1, 0, 0);
    step("F.c10", 0, 6'd0, 6'd3, 0, 1, 0);
    step("F.c11", 0, 6'd0, 6'd3, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rcc_rtc_div_ratio_ctrl.md
RCC_RTC_DIV_RATIO_CTRL -- requirements
Module: rcc_rtc_div_ratio_ctrl

Upstream stage for the RTC clock divider. It accepts software prescaler-ratio writes and presents a multi-bit ratio that is held stable long enough for the divider's 2-stage input synchronizer.

Interface
REQ-001 SHALL have parameter RATIO_WID, default 6, width of the ratio field.
REQ-002 SHALL have parameter SETTLE_CYC, default 4, cycles the ratio is held after each change; legal range 3..255.
REQ-003 SHALL have parameter RST_RATIO, default 0, ratio value after reset (0 = divider bypass).
REQ-004 SHALL have port i_clk, input, 1, the single clock.
REQ-005 SHALL have port rst_n, input, 1, reset: synchronous, active-low.
REQ-006 SHALL have port wr_en, input, 1, one-cycle write strobe.
REQ-007 SHALL have port wr_ratio, input, RATIO_WID, ratio to write; sampled when wr_en=1.
REQ-008 SHALL have port ratio, output, RATIO_WID, registered ratio driven to the divider.
REQ-009 SHALL have port busy, output, 1, high while a settle window is running.
REQ-010 SHALL have port upd_done, output, 1, one-cycle pulse when a settle window completes.
REQ-011 SHALL have port overrun, output, 1, one-cycle pulse when a pending write is overwritten.

Function
REQ-012 SHALL implement FSM states IDLE and SETTLE, plus a settle counter cnt (8 bits) and a one-entry pending register with a valid flag pend_v.
REQ-013 In IDLE, a write with wr_ratio != ratio SHALL, on the sampling edge, load ratio<=wr_ratio, set cnt<=SETTLE_CYC-1, and enter SETTLE with busy=1.
REQ-014 In IDLE, a write with wr_ratio == ratio SHALL be ignored: no busy, no upd_done.
REQ-015 busy SHALL be high for exactly SETTLE_CYC consecutive cycles per applied ratio value.
REQ-016 In SETTLE, cnt SHALL decrement every cycle. The cycle with cnt==0 is the terminal cycle.
REQ-017 A write in SETTLE on a non-terminal cycle SHALL be stored in the pending register with pend_v<=1, regardless of value.
REQ-018 A write in SETTLE on a non-terminal cycle while pend_v=1 SHALL overwrite the pending value and pulse overrun in the next cycle.
REQ-019 On the terminal cycle with pend_v=0 and no write, the FSM SHALL return to IDLE, with busy=0 and upd_done=1 for one cycle.
REQ-020 On the terminal cycle with pend_v=1, the block SHALL:
- load ratio<=pending and reload cnt<=SETTLE_CYC-1;
- stay in SETTLE with busy continuously high;
- pulse upd_done for the completed window;
- clear pend_v, unless a write occurs on the same cycle, in which case that write becomes the new pending value and no overrun is flagged.
REQ-021 On the terminal cycle with pend_v=0 and a write, the block SHALL apply wr_ratio directly as in REQ-020, without the equal-value filter.
REQ-022 ratio SHALL change only on an edge that enters or re-enters a settle window; it SHALL never change while cnt!=0.
REQ-023 upd_done and overrun SHALL be registered, glitch-free, one-cycle pulses; they may assert in the same cycle.

Reset
REQ-024 When rst_n=0 at a rising edge of i_clk, the block SHALL set ratio=RST_RATIO, busy=0, upd_done=0, overrun=0, pend_v=0, cnt=0, state=IDLE.
REQ-025 A reset during SETTLE SHALL discard the active window and any pending write, with no upd_done pulse.
REQ-026 A write sampled in the same cycle as reset SHALL be dropped.

Structure
REQ-027 The default RATIO_WID and the synchronizer stage count (2) SHALL live in the shared rcc package. SETTLE_CYC SHALL default to sync stages + 2.
REQ-028 The FSM state encoding SHALL be local to the module; no sub-module is required.
REQ-029 The block SHALL include an elaboration-time check that SETTLE_CYC is in 3..255.

Verification (SETTLE_CYC=4, RST_RATIO=0)
REQ-030 Reset, then write 5 at cycle 0 -> ratio=5 and busy=1 from cycle 1 to cycle 4; upd_done=1 at cycle 5 only.
REQ-031 Idle with ratio=5, write 5 -> busy stays 0, upd_done stays 0, ratio stays 5.
REQ-032 Write 5 at cycle 0, write 7 at cycle 2 -> ratio=7 from cycle 5; busy high cycles 1..8; upd_done at cycles 5 and 9.
REQ-033 Write 5 at cycle 0, write 7 at cycle 2, write 9 at cycle 3 -> overrun at cycle 4; ratio goes 5 then 9, never 7; final upd_done at cycle 9.
REQ-034 Write 5 at cycle 0, write 6 on terminal cycle 4 -> ratio=6 from cycle 5; busy unbroken; no overrun.
REQ-035 Write 5 at cycle 0, pending write 7 at cycle 1, rst_n=0 at cycle 2 -> ratio=0, busy=0, no upd_done; after release the controller is idle with no pending write.
